// File: rtl/timer_multi.sv
// Multi-hart machine timer: one shared 64-bit mtime, HARTS 64-bit compare channels,
// rtc-driven prescaler, valid/ready word-access peripheral bus.
module timer_multi #(
   parameter int HARTS = 2,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rtc,
   input  logic             timer_valid,
   input  logic             timer_instr,
   input  logic [31:0]      timer_addr,
   input  logic [31:0]      timer_wdata,
   input  logic [3:0]       timer_wstrb,
   output logic [31:0]      timer_rdata,
   output logic             timer_ready,
   output logic [HARTS-1:0] timer_irpt
);

   localparam logic [5:0] W_CTRL     = 6'd0;
   localparam logic [5:0] W_MTIME_LO = 6'd2;
   localparam logic [5:0] W_MTIME_HI = 6'd3;

   logic             en;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] pcnt;
   logic [63:0]      mtime;
   logic [63:0]      cmp [HARTS];

   logic rtc_s1, rtc_s2, rtc_s3;
   logic rtc_tick;
   logic mtime_inc;

   logic             acc, wr;
   logic [5:0]       word;
   logic [31:0]      bmask;
   logic [31:0]      ctrl_word, ctrl_merged;
   logic [31:0]      rd_data;
   logic [HARTS-1:0] sel_cmp_lo, sel_cmp_hi;

   // Fetch flag and undecoded address bits are intentionally ignored.
   logic unused_bits;
   assign unused_bits = &{1'b0, timer_instr, timer_addr[31:8], timer_addr[1:0]};

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [31:0] mask);
      return (old & ~mask) | (wdata & mask);
   endfunction

   assign acc       = timer_valid && !timer_ready;
   assign wr        = acc && (timer_wstrb != 4'b0000);
   assign word      = timer_addr[7:2];
   assign bmask     = {{8{timer_wstrb[3]}}, {8{timer_wstrb[2]}},
                       {8{timer_wstrb[1]}}, {8{timer_wstrb[0]}}};
   assign ctrl_word   = 32'(en) | (32'(div) << 8);
   assign ctrl_merged = merge(ctrl_word, timer_wdata, bmask);

   assign rtc_tick  = rtc_s2 && !rtc_s3;
   assign mtime_inc = rtc_tick && en && (pcnt == div);

   // NOTE: every variable gets a default before the case/loop so no latch is inferred.
   always_comb begin
      rd_data    = 32'h0;
      sel_cmp_lo = '0;
      sel_cmp_hi = '0;
      for (int i = 0; i < HARTS; i++) begin
         sel_cmp_lo[i] = (word == 6'(4 + 2 * i));
         sel_cmp_hi[i] = (word == 6'(5 + 2 * i));
         if (sel_cmp_lo[i]) rd_data = cmp[i][31:0];
         if (sel_cmp_hi[i]) rd_data = cmp[i][63:32];
      end
      case (word)
         W_CTRL:     rd_data = ctrl_word;
         W_MTIME_LO: rd_data = mtime[31:0];
         W_MTIME_HI: rd_data = mtime[63:32];
         default:    ;
      endcase
   end

   // rtc is asynchronous: two-flop synchroniser plus an edge-detect stage.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rtc_s1 <= 1'b0;
         rtc_s2 <= 1'b0;
         rtc_s3 <= 1'b0;
      end else begin
         rtc_s1 <= rtc;
         rtc_s2 <= rtc_s1;
         rtc_s3 <= rtc_s2;
      end
   end

   // A bus write to mtime wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst) begin
         en    <= 1'b0;
         div   <= '0;
         pcnt  <= '0;
         mtime <= 64'h0;
      end else begin
         if (wr && word == W_CTRL) begin
            en   <= ctrl_merged[0];
            div  <= ctrl_merged[8 +: DIV_W];
            pcnt <= '0;
         end else if (rtc_tick && en) begin
            pcnt <= (pcnt == div) ? '0 : pcnt + DIV_W'(1);
         end

         if (wr && word == W_MTIME_LO)
            mtime[31:0] <= merge(mtime[31:0], timer_wdata, bmask);
         else if (wr && word == W_MTIME_HI)
            mtime[63:32] <= merge(mtime[63:32], timer_wdata, bmask);
         else if (mtime_inc)
            mtime <= mtime + 64'd1;
      end
   end

   // NOTE: the compare array is reset because its all-ones value is what keeps
   // interrupts quiet until software programs a compare.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < HARTS; i++) cmp[i] <= '1;
      end else begin
         for (int i = 0; i < HARTS; i++) begin
            if (wr && sel_cmp_lo[i]) cmp[i][31:0]  <= merge(cmp[i][31:0], timer_wdata, bmask);
            if (wr && sel_cmp_hi[i]) cmp[i][63:32] <= merge(cmp[i][63:32], timer_wdata, bmask);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         timer_irpt <= '0;
      end else begin
         for (int i = 0; i < HARTS; i++) timer_irpt[i] <= en && (mtime >= cmp[i]);
      end
   end

   // A held request is refused during its own ready cycle, giving one access per two cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         timer_ready <= 1'b0;
         timer_rdata <= 32'h0;
      end else begin
         timer_ready <= acc;
         if (acc) timer_rdata <= rd_data;
      end
   end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed scenarios plus randomized prescaler/compare
// runs scored against a register-level behavioural model.
module tb_timer_multi;
   localparam int HARTS = 2;
   localparam int DIV_W = 8;
   localparam logic [31:0] CTRL_MASK = 32'h1 | (((32'h1 << DIV_W) - 32'h1) << 8);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rtc = 1'b0;
   logic             timer_valid = 1'b0;
   logic             timer_instr = 1'b0;
   logic [31:0]      timer_addr = '0;
   logic [31:0]      timer_wdata = '0;
   logic [3:0]       timer_wstrb = '0;
   logic [31:0]      timer_rdata;
   logic             timer_ready;
   logic [HARTS-1:0] timer_irpt;

   int checks = 0;
   int errors = 0;

   timer_multi #(.HARTS(HARTS), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .rtc(rtc),
      .timer_valid(timer_valid), .timer_instr(timer_instr), .timer_addr(timer_addr),
      .timer_wdata(timer_wdata), .timer_wstrb(timer_wstrb), .timer_rdata(timer_rdata),
      .timer_ready(timer_ready), .timer_irpt(timer_irpt)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ---------------- behavioural model ----------------
   logic [31:0] m_ctrl;
   logic [63:0] m_mtime;
   logic [63:0] m_cmp [HARTS];
   int          m_pcnt;

   function automatic logic [31:0] bytes_merge(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] strb);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic void model_reset();
      m_ctrl  = 32'h0;
      m_mtime = 64'h0;
      m_pcnt  = 0;
      for (int i = 0; i < HARTS; i++) m_cmp[i] = '1;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] d,
                                       input logic [3:0] strb);
      int off = int'(addr[7:0]);
      if (off == 0) begin
         m_ctrl = bytes_merge(m_ctrl, d, strb) & CTRL_MASK;
         m_pcnt = 0;
      end else if (off == 8)  m_mtime[31:0]  = bytes_merge(m_mtime[31:0], d, strb);
      else if (off == 12)     m_mtime[63:32] = bytes_merge(m_mtime[63:32], d, strb);
      else if (off >= 16 && off < 16 + 8 * HARTS) begin
         int i = (off - 16) / 8;
         if (off % 8 == 0) m_cmp[i][31:0]  = bytes_merge(m_cmp[i][31:0], d, strb);
         else              m_cmp[i][63:32] = bytes_merge(m_cmp[i][63:32], d, strb);
      end
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      int off = int'(addr[7:0]);
      if (off == 0)  return m_ctrl;
      if (off == 8)  return m_mtime[31:0];
      if (off == 12) return m_mtime[63:32];
      if (off >= 16 && off < 16 + 8 * HARTS) begin
         int i = (off - 16) / 8;
         return (off % 8 == 0) ? m_cmp[i][31:0] : m_cmp[i][63:32];
      end
      return 32'h0;
   endfunction

   // One rtc rising edge as seen by software: count toward DIV, then bump mtime.
   function automatic void model_tick();
      int d = int'(m_ctrl[8 +: DIV_W]);
      if (!m_ctrl[0]) return;
      if (m_pcnt == d) begin
         m_pcnt  = 0;
         m_mtime = m_mtime + 64'd1;
      end else m_pcnt = m_pcnt + 1;
   endfunction

   function automatic logic [HARTS-1:0] model_irpt();
      logic [HARTS-1:0] r;
      for (int i = 0; i < HARTS; i++) r[i] = m_ctrl[0] && (m_mtime >= m_cmp[i]);
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic bus(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic got, output logic extra);
      @(negedge clk);
      timer_valid = 1'b1;
      timer_addr  = addr;
      timer_wdata = d;
      timer_wstrb = strb;
      @(negedge clk);
      timer_valid = 1'b0;
      timer_wstrb = 4'h0;
      got   = timer_ready;
      rdata = timer_rdata;
      @(negedge clk);
      extra = timer_ready;
   endtask

   task automatic reg_write(input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] strb);
      logic [31:0] r;
      logic g, e;
      bus(addr, d, strb, r, g, e);
      model_write(addr, d, strb);
   endtask

   task automatic reg_read(input logic [31:0] addr, output logic [31:0] d);
      logic g, e;
      bus(addr, 32'h0, 4'h0, d, g, e);
   endtask

   task automatic rtc_pulses(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk) rtc = 1'b1;
         repeat (3) @(negedge clk);
         rtc = 1'b0;
         repeat (3) @(negedge clk);
         model_tick();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d;
      logic g, e;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      model_reset();
      checks++;
      if (timer_ready !== 1'b0 || timer_rdata !== 32'h0 || timer_irpt !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b rdata=%h irpt=%b required 0/0/0",
                  timer_ready, timer_rdata, timer_irpt);
      end
      for (int a = 16; a <= 20; a += 4) begin
         bus(32'(a), 32'h0, 4'h0, d, g, e);
         checks++;
         if (g !== 1'b1 || e !== 1'b0 || d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_cmp@%h: got ready=%b next=%b rdata=%h required 1/0/ffffffff",
                     a, g, e, d);
         end
      end
      reg_read(32'h08, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL reset_mtime: got %h required 0", d);
      end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      reg_write(32'h10, 32'd5, 4'hF);
      reg_write(32'h14, 32'd0, 4'hF);
      reg_write(32'h00, 32'h1, 4'hF);
      rtc_pulses(4);
      @(negedge clk) rtc = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (timer_irpt[0] !== 1'b0) begin
         errors++;
         $display("FAIL irq_latency_early: got irpt0=%b required 0", timer_irpt[0]);
      end
      @(negedge clk);
      checks++;
      if (timer_irpt !== 2'b01) begin
         errors++;
         $display("FAIL irq_rise: got irpt=%b required 01", timer_irpt);
      end
      rtc = 1'b0;
      repeat (2) @(negedge clk);
      model_tick();
      reg_read(32'h08, d);
      checks++;
      if (d !== 32'd5 || d !== m_mtime[31:0]) begin
         errors++;
         $display("FAIL irq_mtime: got %h required 5", d);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] d;
      reg_write(32'h08, 32'h0, 4'hF);
      reg_write(32'h0C, 32'h0, 4'hF);
      reg_write(32'h00, 32'h301, 4'hF);
      rtc_pulses(8);
      reg_read(32'h08, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL prescale_div3: got mtime=%0d required 2", d);
      end
      reg_write(32'h00, 32'h300, 4'hF);
      rtc_pulses(4);
      reg_read(32'h08, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL prescale_frozen: got mtime=%0d required 2", d);
      end
      reg_read(32'h00, d);
      checks++;
      if (d !== 32'h300) begin
         errors++;
         $display("FAIL ctrl_readback: got %h required 00000300", d);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] lo, hi;
      reg_write(32'h18, 32'h0, 4'hF);
      reg_write(32'h1C, 32'h0, 4'hF);
      reg_write(32'h08, 32'hFFFF_FFFF, 4'hF);
      reg_write(32'h0C, 32'hFFFF_FFFF, 4'hF);
      reg_write(32'h00, 32'h1, 4'hF);
      checks++;
      if (timer_irpt !== 2'b11) begin
         errors++;
         $display("FAIL wrap_before: got irpt=%b required 11", timer_irpt);
      end
      rtc_pulses(1);
      reg_read(32'h08, lo);
      reg_read(32'h0C, hi);
      checks++;
      if ({hi, lo} !== 64'h0 || {hi, lo} !== m_mtime) begin
         errors++;
         $display("FAIL wrap_mtime: got %h%h required 0", hi, lo);
      end
      checks++;
      if (timer_irpt !== 2'b10 || timer_irpt !== model_irpt()) begin
         errors++;
         $display("FAIL wrap_irpt: got irpt=%b required 10", timer_irpt);
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] lo, hi, base;
      base = $urandom;
      reg_write(32'h08, base, 4'hF);
      reg_write(32'h0C, $urandom, 4'hF);
      reg_write(32'h00, 32'h1, 4'hF);
      @(negedge clk) rtc = 1'b1;
      repeat (2) @(negedge clk);
      timer_valid = 1'b1;
      timer_addr  = 32'h08;
      timer_wdata = 32'h0000_AB00;
      timer_wstrb = 4'b0010;
      @(negedge clk);
      timer_valid = 1'b0;
      timer_wstrb = 4'h0;
      checks++;
      if (timer_ready !== 1'b1) begin
         errors++;
         $display("FAIL collide_ready: got %b required 1", timer_ready);
      end
      rtc = 1'b0;
      repeat (3) @(negedge clk);
      model_write(32'h08, 32'h0000_AB00, 4'b0010);
      reg_read(32'h08, lo);
      reg_read(32'h0C, hi);
      checks++;
      if ({hi, lo} !== m_mtime || lo !== ((base & 32'hFFFF_00FF) | 32'h0000_AB00)) begin
         errors++;
         $display("FAIL collide_mtime: got %h%h required %h", hi, lo, m_mtime);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      logic g, e;
      bus(32'h40, 32'h0, 4'h0, d, g, e);
      checks++;
      if (d !== 32'h0 || g !== 1'b1 || e !== 1'b0) begin
         errors++;
         $display("FAIL unmapped_read: got rdata=%h ready=%b next=%b required 0/1/0", d, g, e);
      end
      bus(32'h04, 32'h0, 4'h0, d, g, e);
      checks++;
      if (d !== 32'h0 || g !== 1'b1) begin
         errors++;
         $display("FAIL hole_read: got rdata=%h ready=%b required 0/1", d, g);
      end
      bus(32'h40, $urandom, 4'hF, d, g, e);
      checks++;
      if (g !== 1'b1 || e !== 1'b0) begin
         errors++;
         $display("FAIL unmapped_write: got ready=%b next=%b required 1/0", g, e);
      end
      for (int a = 0; a < 16 + 8 * HARTS; a += 4) begin
         reg_read(32'(a), d);
         checks++;
         if (d !== model_read(32'(a))) begin
            errors++;
            $display("FAIL unmapped_side@%h: got %h required %h", a, d, model_read(32'(a)));
         end
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      @(negedge clk);
      timer_valid = 1'b1;
      timer_addr  = 32'h10;
      timer_wstrb = 4'h0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (timer_ready) pulses++;
         checks++;
         if (timer_ready !== logic'(k % 2) ||
             (timer_ready && timer_rdata !== model_read(32'h10))) begin
            errors++;
            $display("FAIL held_valid cycle %0d: got ready=%b rdata=%h required %b/%h",
                     k, timer_ready, timer_rdata, k % 2, model_read(32'h10));
         end
      end
      timer_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL held_valid_count: got %0d required 4", pulses);
      end
   endtask

   task automatic test_random();
      logic [31:0] lo, hi;
      for (int it = 0; it < 8; it++) begin
         int base = $urandom_range(0, 1000);
         reg_write(32'h08, 32'(base), 4'hF);
         reg_write(32'h0C, 32'h0, 4'hF);
         for (int i = 0; i < HARTS; i++) begin
            reg_write(32'h10 + 32'(8 * i), 32'(base + $urandom_range(0, 8)), 4'hF);
            reg_write(32'h14 + 32'(8 * i), 32'h0, 4'hF);
         end
         reg_write(32'h00, (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 5) != 0),
                   4'hF);
         rtc_pulses($urandom_range(0, 12));
         checks++;
         if (timer_irpt !== model_irpt()) begin
            errors++;
            $display("FAIL random_irpt it%0d: got %b required %b", it, timer_irpt, model_irpt());
         end
         reg_read(32'h08, lo);
         reg_read(32'h0C, hi);
         checks++;
         if ({hi, lo} !== m_mtime) begin
            errors++;
            $display("FAIL random_mtime it%0d: got %h%h required %h", it, hi, lo, m_mtime);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      reg_write(32'h10, 32'h0, 4'hF);
      reg_write(32'h08, 32'h1234, 4'hF);
      reg_write(32'h00, 32'h501, 4'hF);
      @(negedge clk);
      timer_valid = 1'b1;
      timer_addr  = 32'h10;
      timer_wstrb = 4'h0;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (timer_ready !== 1'b0 || timer_irpt !== '0) begin
            errors++;
            $display("FAIL reset_mid cycle %0d: got ready=%b irpt=%b required 0/0",
                     k, timer_ready, timer_irpt);
         end
      end
      timer_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      for (int a = 0; a < 16 + 8 * HARTS; a += 4) begin
         reg_read(32'(a), d);
         checks++;
         if (d !== model_read(32'(a))) begin
            errors++;
            $display("FAIL reset_mid_reg@%h: got %h required %h", a, d, model_read(32'(a)));
         end
      end
   endtask

   initial begin
      test_reset();
      test_irq();
      test_prescale();
      test_wrap();
      test_same_cycle();
      test_unmapped();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
